// File: rtl/hexbus_pkg.sv
// ============================================================================
// hexbus_pkg : shared character constants and EOL mode encodings for the
//              hexbus response path.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hexbus_pkg;

  localparam logic [6:0] HB_CR   = 7'h0d;
  localparam logic [6:0] HB_LF   = 7'h0a;
  localparam logic [6:0] HB_IDLE = 7'h7f;

  typedef enum logic [1:0] {
    HB_EOL_NONE = 2'b00,
    HB_EOL_CR   = 2'b01,
    HB_EOL_LF   = 2'b10,
    HB_EOL_CRLF = 2'b11
  } hb_eol_e;

  // First character of a line-end sequence; only the LF-only mode opens with LF.
  function automatic logic [6:0] hb_first_eol(input hb_eol_e mode);
    return (mode == HB_EOL_LF) ? HB_LF : HB_CR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hblinefmt_if.sv
// ============================================================================
// hblinefmt_if : character stream between the hexbus encoder, the line
//                formatter and the UART transmit FIFO.
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface hblinefmt_if
  import hexbus_pkg::*;
#(
  parameter int DW = 7
);

  hb_eol_e         i_mode;
  logic            i_stb;
  logic [DW-1:0]   i_byte;
  logic            o_busy;
  logic            o_stb;
  logic [DW-1:0]   o_byte;
  logic            i_busy;

  modport slave (
    input  i_mode, i_stb, i_byte, i_busy,
    output o_busy, o_stb, o_byte
  );

  modport master (
    output i_mode, i_stb, i_byte, i_busy,
    input  o_busy, o_stb, o_byte
  );

endinterface

`default_nettype wire

// File: rtl/hblinefmt.sv
// ============================================================================
// hblinefmt : registered line formatter; inserts CR/LF/CRLF line ends on
//             idle or after MAXLEN characters.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hblinefmt
  import hexbus_pkg::*;
#(
  parameter int DW          = 7,
  parameter int MAXLEN      = 64,
  parameter int IDLE_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hblinefmt_if.slave  bus
);

  localparam int CW = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;
  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  localparam logic [CW-1:0] COL_WRAP  = CW'(MAXLEN);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(IDLE_CYCLES);
  localparam logic [DW-1:0] BYTE_NONE = {DW{1'b1}};
  localparam logic [DW-1:0] BYTE_CR   = DW'(HB_CR);
  localparam logic [DW-1:0] BYTE_LF   = DW'(HB_LF);

  logic            o_stb_q,     o_stb_d;
  logic [DW-1:0]   o_byte_q,    o_byte_d;
  logic [CW-1:0]   col_q,       col_d;
  logic [IW-1:0]   idle_cnt_q,  idle_cnt_d;
  logic            eol2_pend_q, eol2_pend_d;
  logic            wrap_pend_q, wrap_pend_d;
  hb_eol_e         eol_mode_q,  eol_mode_d;

  logic            free;
  logic            idle_hit;
  logic [CW-1:0]   col_inc;
  logic            is_eol_char;

  assign free        = !o_stb_q || !bus.i_busy;
  assign col_inc     = col_q + CW'(1);
  assign is_eol_char = (bus.i_byte == BYTE_CR) || (bus.i_byte == BYTE_LF);
  assign idle_hit    = (idle_cnt_q == IDLE_LIM);

  assign bus.o_busy  = !free || eol2_pend_q || wrap_pend_q;
  assign bus.o_stb   = o_stb_q;
  assign bus.o_byte  = o_byte_q;

  always_comb begin
    o_stb_d     = o_stb_q;
    o_byte_d    = o_byte_q;
    col_d       = col_q;
    idle_cnt_d  = idle_cnt_q;
    eol2_pend_d = eol2_pend_q;
    wrap_pend_d = wrap_pend_q;
    eol_mode_d  = eol_mode_q;

    // Idle time is measured from acceptance: a stalled output is not idle.
    if (bus.i_stb || (o_stb_q && bus.i_busy)) begin
      idle_cnt_d = '0;
    end else if (!idle_hit) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end

    if (free) begin
      if (eol2_pend_q) begin
        o_stb_d     = 1'b1;
        o_byte_d    = BYTE_LF;
        eol2_pend_d = 1'b0;
        col_d       = '0;
      end else if (wrap_pend_q) begin
        o_stb_d     = 1'b1;
        o_byte_d    = DW'(hb_first_eol(eol_mode_q));
        wrap_pend_d = 1'b0;
        if (eol_mode_q == HB_EOL_CRLF) begin
          eol2_pend_d = 1'b1;
        end else begin
          col_d = '0;
        end
      end else if (bus.i_stb) begin
        o_stb_d  = 1'b1;
        o_byte_d = bus.i_byte;
        if (is_eol_char) begin
          col_d = '0;
        end else begin
          // Saturate so a long unwrapped run in pass-through mode cannot alias to 0.
          if (col_q != {CW{1'b1}}) begin
            col_d = col_inc;
          end
          if ((MAXLEN != 0) && (bus.i_mode != HB_EOL_NONE) && (col_inc == COL_WRAP)) begin
            wrap_pend_d = 1'b1;
            eol_mode_d  = bus.i_mode;
          end
        end
      end else if (idle_hit && (col_q != '0) && (bus.i_mode != HB_EOL_NONE)) begin
        o_stb_d    = 1'b1;
        o_byte_d   = DW'(hb_first_eol(bus.i_mode));
        eol_mode_d = bus.i_mode;
        if (bus.i_mode == HB_EOL_CRLF) begin
          eol2_pend_d = 1'b1;
        end else begin
          col_d = '0;
        end
      end else begin
        o_stb_d  = 1'b0;
        o_byte_d = BYTE_NONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb_q     <= 1'b0;
      o_byte_q    <= BYTE_NONE;
      col_q       <= '0;
      idle_cnt_q  <= '0;
      eol2_pend_q <= 1'b0;
      wrap_pend_q <= 1'b0;
      eol_mode_q  <= HB_EOL_NONE;
    end else begin
      o_stb_q     <= o_stb_d;
      o_byte_q    <= o_byte_d;
      col_q       <= col_d;
      idle_cnt_q  <= idle_cnt_d;
      eol2_pend_q <= eol2_pend_d;
      wrap_pend_q <= wrap_pend_d;
      eol_mode_q  <= eol_mode_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hblinefmt.sv
// ============================================================================
// tb_hblinefmt : directed self-checking bench for hblinefmt (two parameter
//                sets: wrap at 4 / no idle delay, and idle delay of 3).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_hblinefmt;
  import hexbus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hblinefmt_if #(.DW(7)) b0 ();
  hblinefmt_if #(.DW(7)) b1 ();

  hblinefmt #(.DW(7), .MAXLEN(4), .IDLE_CYCLES(0)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b0.slave)
  );

  hblinefmt #(.DW(7), .MAXLEN(64), .IDLE_CYCLES(3)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic stb, input logic [6:0] byt);
    if (d == 0) begin
      b0.i_stb  = stb;
      b0.i_byte = byt;
    end else begin
      b1.i_stb  = stb;
      b1.i_byte = byt;
    end
  endtask

  task automatic chk_out(input string tag, input int d, input logic stb, input logic [6:0] byt);
    logic       s;
    logic [6:0] b;
    s = (d == 0) ? b0.o_stb  : b1.o_stb;
    b = (d == 0) ? b0.o_byte : b1.o_byte;
    chk({tag, "_stb"},  32'(s), 32'(stb));
    chk({tag, "_byte"}, 32'(b), 32'(byt));
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk_out(tag, d, 1'b0, 7'h7f);
  endtask

  // Wrap test: input presented after each tick, and expected output/busy.
  logic [6:0] t2_in   [6] = '{7'h32, 7'h33, 7'h34, 7'h35, 7'h35, 7'h36};
  logic [6:0] t2_out  [9] = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h0d, 7'h35, 7'h36, 7'h0d, 7'h7f};
  logic       t2_busy [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] t4_in   [6] = '{7'h61, 7'h62, 7'h63, 7'h64, 7'h65, 7'h0a};

  initial begin
    rst       = 1'b1;
    b0.i_mode = HB_EOL_NONE; b0.i_stb = 1'b0; b0.i_byte = '0; b0.i_busy = 1'b0;
    b1.i_mode = HB_EOL_NONE; b1.i_stb = 1'b0; b1.i_byte = '0; b1.i_busy = 1'b0;
    tick();
    chk("rst_busy_during", 32'(b0.o_busy), 32'd0);
    tick();
    chk_idle("rst0", 0);
    chk_idle("rst1", 1);
    chk("rst1_busy", 32'(b1.o_busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_busy0", 32'(b0.o_busy), 32'd0);
    chk_idle("rel0", 0);

    // CRLF, no idle delay: A, B, then one CR/LF and silence.
    b0.i_mode = HB_EOL_CRLF;
    drv(0, 1'b1, 7'h41); tick(); chk_out("t1_a", 0, 1'b1, 7'h41);
    drv(0, 1'b1, 7'h42); tick(); chk_out("t1_b", 0, 1'b1, 7'h42);
    drv(0, 1'b0, 7'h00); tick(); chk_out("t1_cr", 0, 1'b1, 7'h0d);
    tick(); chk_out("t1_lf", 0, 1'b1, 7'h0a);
    tick(); chk_idle("t1_idle_a", 0);
    tick(); chk_idle("t1_idle_b", 0);

    // CR mode, MAXLEN=4: forced wrap after "4".
    b0.i_mode = HB_EOL_CR;
    drv(0, 1'b1, 7'h31);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_out($sformatf("t2_out%0d", k), 0, (k != 8), t2_out[k]);
      chk($sformatf("t2_busy%0d", k), 32'(b0.o_busy), 32'(t2_busy[k]));
      if (k < 6) drv(0, 1'b1, t2_in[k]);
      else       drv(0, 1'b0, 7'h00);
    end

    // LF mode: LF held stable under downstream stall.
    b0.i_mode = HB_EOL_LF;
    drv(0, 1'b1, 7'h5a); tick(); chk_out("t3_z", 0, 1'b1, 7'h5a);
    drv(0, 1'b0, 7'h00); tick(); chk_out("t3_lf", 0, 1'b1, 7'h0a);
    drv(0, 1'b1, 7'h51);
    b0.i_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("t3_hold%0d", k), 0, 1'b1, 7'h0a);
      chk($sformatf("t3_busy%0d", k), 32'(b0.o_busy), 32'd1);
    end
    b0.i_busy = 1'b0;
    tick(); chk_out("t3_q", 0, 1'b1, 7'h51);
    drv(0, 1'b0, 7'h00);
    tick(); chk_out("t3_lf2", 0, 1'b1, 7'h0a);
    tick(); chk_idle("t3_idle", 0);

    // Mode 00: pure pass-through, no wrap past MAXLEN.
    b0.i_mode = HB_EOL_NONE;
    drv(0, 1'b1, t4_in[0]);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("t4_out%0d", k), 0, 1'b1, t4_in[k]);
      chk($sformatf("t4_busy%0d", k), 32'(b0.o_busy), 32'd0);
      if (k < 5) drv(0, 1'b1, t4_in[k+1]);
      else       drv(0, 1'b0, 7'h00);
    end
    tick(); chk_idle("t4_idle_a", 0);
    tick(); chk_idle("t4_idle_b", 0);

    // IDLE_CYCLES=3: CR four cycles after X is accepted.
    b1.i_mode = HB_EOL_CRLF;
    drv(1, 1'b1, 7'h58); tick(); chk_out("t5_x", 1, 1'b1, 7'h58);
    drv(1, 1'b0, 7'h00);
    for (int k = 0; k < 3; k++) begin
      tick(); chk_idle($sformatf("t5_wait%0d", k), 1);
    end
    tick(); chk_out("t5_cr", 1, 1'b1, 7'h0d);
    tick(); chk_out("t5_lf", 1, 1'b1, 7'h0a);
    tick(); chk_idle("t5_idle", 1);

    // Y on the expiry cycle pre-empts the idle line end.
    drv(1, 1'b1, 7'h58); tick(); chk_out("t5b_x", 1, 1'b1, 7'h58);
    drv(1, 1'b0, 7'h00);
    tick(); chk_idle("t5b_w0", 1);
    tick(); chk_idle("t5b_w1", 1);
    tick(); chk_idle("t5b_w2", 1);
    drv(1, 1'b1, 7'h59); tick(); chk_out("t5b_y", 1, 1'b1, 7'h59);
    drv(1, 1'b0, 7'h00);
    for (int k = 0; k < 3; k++) begin
      tick(); chk_idle($sformatf("t5b_wait%0d", k), 1);
    end
    tick(); chk_out("t5b_cr", 1, 1'b1, 7'h0d);
    tick(); chk_out("t5b_lf", 1, 1'b1, 7'h0a);
    tick(); chk_idle("t5b_idle", 1);

    // Explicit CR resets the column: no idle line end until B.
    drv(1, 1'b1, 7'h41); tick(); chk_out("t6_a", 1, 1'b1, 7'h41);
    drv(1, 1'b1, 7'h0d); tick(); chk_out("t6_cr_in", 1, 1'b1, 7'h0d);
    drv(1, 1'b0, 7'h00);
    for (int k = 0; k < 6; k++) begin
      tick(); chk_idle($sformatf("t6_gap%0d", k), 1);
    end
    drv(1, 1'b1, 7'h42); tick(); chk_out("t6_b", 1, 1'b1, 7'h42);
    drv(1, 1'b0, 7'h00);
    for (int k = 0; k < 3; k++) begin
      tick(); chk_idle($sformatf("t6_wait%0d", k), 1);
    end
    tick(); chk_out("t6_cr", 1, 1'b1, 7'h0d);
    tick(); chk_out("t6_lf", 1, 1'b1, 7'h0a);
    tick(); chk_idle("t6_idle", 1);

    // Reset while the LF of a CRLF is still owed.
    b0.i_mode = HB_EOL_CRLF;
    drv(0, 1'b1, 7'h52); tick(); chk_out("t7_r", 0, 1'b1, 7'h52);
    drv(0, 1'b0, 7'h00); tick(); chk_out("t7_cr", 0, 1'b1, 7'h0d);
    chk("t7_busy_pend", 32'(b0.o_busy), 32'd1);
    rst = 1'b1;
    tick(); chk_idle("t7_rst", 0);
    chk("t7_busy_rst", 32'(b0.o_busy), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_idle($sformatf("t7_after%0d", k), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
